// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-SRAM port arbiter: FSM states, port IDs, wait counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DM = 1'b1
    } port_e;

    // Holds WAIT_CYC-1 for WAIT_CYC up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF request port, DM request port, SRAM port and pipeline stall.
// Latency: n/a (wiring only).
// Backpressure: requests are held until their done pulse; stall reports open requests.
// Modports: slave = arbiter side, master = core + SRAM side.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_done, if_rdata, dm_done, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_done, if_rdata, dm_done, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/arb_pick.sv
// Combinational winner select between the IF and DM request ports.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller only uses gnt_o while idle with a request pending.
// Ports: if_req_i, dm_req_i (requests), last_gnt_i (port served last), gnt_o (winner).
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic  if_req_i,
    input  logic  dm_req_i,
    input  port_e last_gnt_i,
    output port_e gnt_o
);

    always_comb begin
        gnt_o = PORT_DM;
        if (if_req_i && !dm_req_i) begin
            gnt_o = PORT_IF;
        end else if (if_req_i && dm_req_i && RR_EN && (last_gnt_i == PORT_DM)) begin
            // Tie in round-robin mode: the port that was not served last wins.
            gnt_o = PORT_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF and DM accesses onto one single-port SRAM with WAIT_CYC wait states.
// Latency: request sampled at edge N -> done pulse in cycle N+WAIT_CYC+2.
// Backpressure: one access at a time; waiting requests are held and stall stays high.
// Ports: clk, rst (sync, active-high), bus (slave modport: IF/DM request ports, SRAM port, stall).
// Build option: define ARB_RR_EN for round-robin on contention (default: fixed DM over IF).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    port_e             port_q, port_d;
    port_e             gnt;
    port_e             last_gnt;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic              start;
    logic              finish;

    // A transaction starts from IDLE (including a done cycle) and finishes on the last WAIT cycle.
    assign start  = (state_q == ST_IDLE) && (bus.if_req || bus.dm_req);
    assign finish = (state_q == ST_WAIT) && (cnt_q == '0);

`ifdef ARB_RR_EN
    localparam bit RR_EN = 1'b1;
    port_e last_gnt_q, last_gnt_d;

    assign last_gnt_d = start ? gnt : last_gnt_q;

    // Resets to IF so that DM wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) last_gnt_q <= PORT_IF;
        else     last_gnt_q <= last_gnt_d;
    end
    assign last_gnt = last_gnt_q;
`else
    localparam bit RR_EN = 1'b0;
    assign last_gnt = PORT_IF;
`endif

    arb_pick #(.RR_EN(RR_EN)) u_pick (
        .if_req_i   (bus.if_req),
        .dm_req_i   (bus.dm_req),
        .last_gnt_i (last_gnt),
        .gnt_o      (gnt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_ISSUE;
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(WAIT_CYC - 1);
            end
            ST_WAIT:  begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Transaction latch on grant, read-data capture and done pulse on finish.
    always_comb begin
        port_d     = port_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        if (start) begin
            port_d = gnt;
            if (gnt == PORT_DM) begin
                we_d    = bus.dm_we;
                addr_d  = bus.dm_addr;
                wdata_d = bus.dm_wdata;
            end else begin
                we_d    = 1'b0;
                addr_d  = bus.if_addr;
            end
        end
        if (finish) begin
            if (port_q == PORT_DM) begin
                dm_done_d = 1'b1;
                // Writes leave the last DM read result untouched.
                if (!we_q) dm_rdata_d = bus.mem_rdata;
            end else begin
                if_done_d  = 1'b1;
                if_rdata_d = bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            port_q     <= PORT_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
        end else begin
            port_q     <= port_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
        end
    end

    // Output logic.
    always_comb begin
        bus.mem_en = (state_q == ST_ISSUE);
        bus.mem_we = (state_q == ST_ISSUE) && we_q;
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.stall     = (bus.if_req && !if_done_q) || (bus.dm_req && !dm_done_q);

endmodule
